// File: rtl/audio_sample_sequencer.sv
// Sequences ADC samples through an external IIR filter into a small FIFO
// that is drained by PWM ready strobes; both strobes arrive asynchronously.
module audio_sample_sequencer #(
    parameter int          N            = 10,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          FILT_LAT     = 2,
    parameter logic [15:0] F_DEFAULT    = 16'd1000,
    parameter logic        TYPE_DEFAULT = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          adc_valid,
    input  logic [N-1:0]                  adc_data,
    input  logic                          pwm_ready,
    output logic [N-1:0]                  x_cur,
    output logic [N-1:0]                  x_prev,
    output logic [N-1:0]                  y_prev,
    input  logic [N-1:0]                  filt_out,
    input  logic [15:0]                   cfg_f,
    input  logic                          cfg_type,
    input  logic                          cfg_wr,
    output logic [15:0]                   f_act,
    output logic                          type_act,
    output logic [N-1:0]                  duty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          overrun,
    output logic [7:0]                    drop_cnt,
    output logic [7:0]                    underrun_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(FILT_LAT) + 1;
    localparam logic [N-1:0] MID = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CAPTURE, SETTLE, WRITE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s_meta_q, s_sync_q, s_prev_q;
    logic          p_meta_q, p_sync_q, p_prev_q;
    logic          s_evt, p_evt;
    logic          pending_q, pending_d;
    logic [N-1:0]  x_cur_q, x_cur_d, x_prev_q, x_prev_d, y_prev_q, y_prev_d;
    logic [N-1:0]  duty_q, duty_d;
    logic [15:0]   f_act_q, f_act_d, f_shadow_q, f_shadow_d;
    logic          type_act_q, type_act_d, type_shadow_q, type_shadow_d;
    logic [N-1:0]  fifo_mem_q [FIFO_DEPTH];
    logic [N-1:0]  fifo_mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d, underrun_cnt_q, underrun_cnt_d;
    logic          push, pop, full, wr_drop, evt_drop;
    logic [8:0]    drop_sum;

    assign s_evt = s_sync_q & ~s_prev_q;
    assign p_evt = p_sync_q & ~p_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            {s_meta_q, s_sync_q, s_prev_q} <= '0;
            {p_meta_q, p_sync_q, p_prev_q} <= '0;
            pending_q      <= 1'b0;
            x_cur_q        <= MID;
            x_prev_q       <= MID;
            y_prev_q       <= MID;
            duty_q         <= MID;
            f_act_q        <= F_DEFAULT;
            f_shadow_q     <= F_DEFAULT;
            type_act_q     <= TYPE_DEFAULT;
            type_shadow_q  <= TYPE_DEFAULT;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            overrun_q      <= 1'b0;
            drop_cnt_q     <= '0;
            underrun_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            {s_meta_q, s_sync_q, s_prev_q} <= {adc_valid, s_meta_q, s_sync_q};
            {p_meta_q, p_sync_q, p_prev_q} <= {pwm_ready, p_meta_q, p_sync_q};
            pending_q      <= pending_d;
            x_cur_q        <= x_cur_d;
            x_prev_q       <= x_prev_d;
            y_prev_q       <= y_prev_d;
            duty_q         <= duty_d;
            f_act_q        <= f_act_d;
            f_shadow_q     <= f_shadow_d;
            type_act_q     <= type_act_d;
            type_shadow_q  <= type_shadow_d;
            fifo_mem_q     <= fifo_mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            overrun_q      <= overrun_d;
            drop_cnt_q     <= drop_cnt_d;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (s_evt || pending_q) state_d = CAPTURE;
            CAPTURE: state_d = SETTLE;
            SETTLE:  if (cnt_q == CW'(FILT_LAT - 1)) state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d          = cnt_q;
        pending_d      = pending_q;
        x_cur_d        = x_cur_q;
        x_prev_d       = x_prev_q;
        y_prev_d       = y_prev_q;
        duty_d         = duty_q;
        f_act_d        = f_act_q;
        type_act_d     = type_act_q;
        f_shadow_d     = f_shadow_q;
        type_shadow_d  = type_shadow_q;
        fifo_mem_d     = fifo_mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        overrun_d      = overrun_q;
        drop_cnt_d     = drop_cnt_q;
        underrun_cnt_d = underrun_cnt_q;
        push           = 1'b0;
        wr_drop        = 1'b0;
        evt_drop       = 1'b0;
        full           = (level_q == LW'(FIFO_DEPTH));
        pop            = p_evt && (level_q != '0);

        case (state_q)
            // A coincident new event takes over the pending slot, so it stays set.
            IDLE: if (pending_q && !s_evt) pending_d = 1'b0;
            CAPTURE: begin
                x_prev_d   = x_cur_q;
                x_cur_d    = adc_data;
                f_act_d    = f_shadow_q;
                type_act_d = type_shadow_q;
                cnt_d      = '0;
            end
            SETTLE: cnt_d = cnt_q + CW'(1);
            WRITE: begin
                y_prev_d = filt_out;
                if (!full || pop) push = 1'b1;
                else              wr_drop = 1'b1;
            end
            default: ;
        endcase

        if (state_q != IDLE && s_evt) begin
            if (!pending_q) pending_d = 1'b1;
            else            evt_drop  = 1'b1;
        end

        if (cfg_wr) begin
            f_shadow_d    = cfg_f;
            type_shadow_d = cfg_type;
        end

        // Pop sees the pre-push state: an empty FIFO underruns even if a push lands now.
        if (pop) begin
            duty_d   = fifo_mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else if (p_evt && underrun_cnt_q != 8'hFF) begin
            underrun_cnt_d = underrun_cnt_q + 8'd1;
        end
        if (push) begin
            fifo_mem_d[wr_ptr_q] = filt_out;
            wr_ptr_d             = wr_ptr_q + AW'(1);
        end
        level_d = level_q + LW'(push) - LW'(pop);

        drop_sum = {1'b0, drop_cnt_q} + 9'(wr_drop) + 9'(evt_drop);
        if (wr_drop || evt_drop) begin
            overrun_d  = 1'b1;
            drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    assign x_cur        = x_cur_q;
    assign x_prev       = x_prev_q;
    assign y_prev       = y_prev_q;
    assign duty         = duty_q;
    assign f_act        = f_act_q;
    assign type_act     = type_act_q;
    assign fifo_level   = level_q;
    assign busy         = (state_q != IDLE);
    assign overrun      = overrun_q;
    assign drop_cnt     = drop_cnt_q;
    assign underrun_cnt = underrun_cnt_q;

endmodule
